pcs_rx_block_sync: RTL and testbench

PCS_RX_BLOCK_SYNC -- requirements
Module: pcs_rx_block_sync

---
 rtl/pcs_rx_block_sync_pkg.sv | 17 +
 rtl/pcs_rx_block_sync.sv | 133 +++++++++++++
 tb/tb_pcs_rx_block_sync.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pcs_rx_block_sync_pkg.sv
// pcs_rx_block_sync_pkg: shared PCS rx constants, window defaults and block-sync state type.
package pcs_rx_block_sync_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    localparam int SH_CNT_MAX_DEF   = 64;
    localparam int SH_INVLD_MAX_DEF = 16;

    typedef enum logic [1:0] {
        INIT         = 2'd0,
        TEST         = 2'd1,
        SLIP_WAIT_ST = 2'd2,
        LOCKED       = 2'd3
    } bsync_state_e;

endpackage

// File: rtl/pcs_rx_block_sync.sv
// pcs_rx_block_sync: sync-header block lock FSM between the rx gearbox (slip consumer) and the descrambler.
module pcs_rx_block_sync
    import pcs_rx_block_sync_pkg::*;
#(
    parameter int HEAD_W       = 2,
    parameter int SH_CNT_MAX   = SH_CNT_MAX_DEF,
    parameter int SH_INVLD_MAX = SH_INVLD_MAX_DEF,
    parameter int SLIP_WAIT    = 2
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              signal_v_i,
    input  logic              valid_i,
    input  logic [HEAD_W-1:0] head_i,
    output logic              slip_v_o,
    output logic              lock_v_o,
    output logic [4:0]        sh_invld_cnt_o
);

    localparam int CNT_W  = $clog2(SH_CNT_MAX + 1);
    localparam int WAIT_W = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((SLIP_WAIT > 0) ? SLIP_WAIT - 1 : 0);

    bsync_state_e      r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_sh_cnt, w_sh_cnt_nxt, w_cnt_inc;
    logic [4:0]        r_invld, w_invld_nxt, w_invld_inc;
    logic [WAIT_W-1:0] r_wait, w_wait_nxt;
    logic              r_slip, w_slip_nxt;
    logic              r_lock, w_lock_nxt;
    logic              w_eval, w_hdr_ok, w_cnt_full, w_invld_full, w_wait_done;

    assign w_eval       = valid_i & signal_v_i;
    assign w_hdr_ok     = (head_i == HEAD_W'(SYNC_DATA)) || (head_i == HEAD_W'(SYNC_CTRL));
    assign w_cnt_inc    = r_sh_cnt + CNT_W'(1);
    assign w_invld_inc  = r_invld + 5'd1;
    assign w_cnt_full   = (w_cnt_inc == CNT_W'(SH_CNT_MAX));
    assign w_invld_full = (w_invld_inc == 5'(SH_INVLD_MAX));
    // The block that triggered the slip is already behind us; only later blocks are discarded.
    assign w_wait_done  = (SLIP_WAIT == 0) || (valid_i && r_wait == WAIT_LAST);

    always_comb begin
        w_state_nxt  = r_state;
        w_sh_cnt_nxt = r_sh_cnt;
        w_invld_nxt  = r_invld;
        w_wait_nxt   = r_wait;
        w_slip_nxt   = 1'b0;
        w_lock_nxt   = r_lock;
        if (!signal_v_i) begin
            w_state_nxt  = INIT;
            w_sh_cnt_nxt = '0;
            w_invld_nxt  = '0;
            w_wait_nxt   = '0;
            w_lock_nxt   = 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    w_state_nxt  = TEST;
                    w_sh_cnt_nxt = '0;
                    w_invld_nxt  = '0;
                    w_wait_nxt   = '0;
                    w_lock_nxt   = 1'b0;
                end
                TEST: begin
                    if (w_eval && !w_hdr_ok) begin
                        w_state_nxt  = SLIP_WAIT_ST;
                        w_slip_nxt   = 1'b1;
                        w_sh_cnt_nxt = '0;
                        w_invld_nxt  = '0;
                        w_wait_nxt   = '0;
                    end else if (w_eval && w_cnt_full) begin
                        w_state_nxt  = LOCKED;
                        w_lock_nxt   = 1'b1;
                        w_sh_cnt_nxt = '0;
                        w_invld_nxt  = '0;
                    end else if (w_eval) begin
                        w_sh_cnt_nxt = w_cnt_inc;
                    end
                end
                SLIP_WAIT_ST: begin
                    if (w_wait_done) begin
                        w_state_nxt  = TEST;
                        w_wait_nxt   = '0;
                        w_sh_cnt_nxt = '0;
                        w_invld_nxt  = '0;
                    end else if (valid_i) begin
                        w_wait_nxt = r_wait + WAIT_W'(1);
                    end
                end
                LOCKED: begin
                    // Unlock wins over window rollover when both land on the same header.
                    if (w_eval && !w_hdr_ok && w_invld_full) begin
                        w_state_nxt  = SLIP_WAIT_ST;
                        w_lock_nxt   = 1'b0;
                        w_slip_nxt   = 1'b1;
                        w_sh_cnt_nxt = '0;
                        w_invld_nxt  = '0;
                        w_wait_nxt   = '0;
                    end else if (w_eval && w_cnt_full) begin
                        w_sh_cnt_nxt = '0;
                        w_invld_nxt  = '0;
                    end else if (w_eval) begin
                        w_sh_cnt_nxt = w_cnt_inc;
                        w_invld_nxt  = w_hdr_ok ? r_invld : w_invld_inc;
                    end
                end
                default: w_state_nxt = INIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state  <= INIT;
            r_sh_cnt <= '0;
            r_invld  <= '0;
            r_wait   <= '0;
            r_slip   <= 1'b0;
            r_lock   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_sh_cnt <= w_sh_cnt_nxt;
            r_invld  <= w_invld_nxt;
            r_wait   <= w_wait_nxt;
            r_slip   <= w_slip_nxt;
            r_lock   <= w_lock_nxt;
        end
    end

    assign slip_v_o       = r_slip;
    assign lock_v_o       = r_lock;
    assign sh_invld_cnt_o = r_invld;

endmodule

// File: tb/tb_pcs_rx_block_sync.sv
// tb_pcs_rx_block_sync: scenario bench for block lock, slip, unlock, signal loss and reset behaviour.
module tb_pcs_rx_block_sync;

    logic       clk = 1'b0;
    logic       nreset;
    logic       signal_v_i;
    logic       valid_i;
    logic [1:0] head_i;
    logic       slip_v_o;
    logic       lock_v_o;
    logic [4:0] sh_invld_cnt_o;

    logic [6:0] q_exp[$];
    logic [6:0] e;
    int         n_chk = 0;
    int         n_fail = 0;

    pcs_rx_block_sync #(
        .HEAD_W      (2),
        .SH_CNT_MAX  (64),
        .SH_INVLD_MAX(16),
        .SLIP_WAIT   (2)
    ) dut (
        .clk           (clk),
        .nreset        (nreset),
        .signal_v_i    (signal_v_i),
        .valid_i       (valid_i),
        .head_i        (head_i),
        .slip_v_o      (slip_v_o),
        .lock_v_o      (lock_v_o),
        .sh_invld_cnt_o(sh_invld_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ex(input bit l, input bit s, input int n);
        return {l, s, 5'(n)};
    endfunction

    function automatic logic [6:0] obs();
        return {lock_v_o, slip_v_o, sh_invld_cnt_o};
    endfunction

    task automatic cyc(input logic s, input logic v, input logic [1:0] h);
        signal_v_i = s;
        valid_i    = v;
        head_i     = h;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nreset = 1'b0; signal_v_i = 1'b0; valid_i = 1'b0; head_i = 2'b00;
        #3;
        n_chk++;
        if (obs() !== ex(0, 0, 0)) begin n_fail++; $display("FAIL reset_init got %b expected %b", obs(), ex(0, 0, 0)); end
        for (int i = 0; i < 2; i++) begin
            q_exp.push_back(ex(0, 0, 0));
            cyc(1, 1, 2'b01);
            e = q_exp.pop_front(); n_chk++;
            if (obs() !== e) begin n_fail++; $display("FAIL reset_hold[%0d] got %b expected %b", i, obs(), e); end
        end
        nreset = 1'b1;
    endtask

    task automatic test_lock();
        q_exp.push_back(ex(0, 0, 0));
        cyc(1, 1, 2'b01);
        e = q_exp.pop_front(); n_chk++;
        if (obs() !== e) begin n_fail++; $display("FAIL lock_first_edge got %b expected %b", obs(), e); end
        for (int i = 0; i < 64; i++) begin
            q_exp.push_back(ex(i == 63, 0, 0));
            cyc(1, 1, (i % 2) ? 2'b10 : 2'b01);
            e = q_exp.pop_front(); n_chk++;
            if (obs() !== e) begin n_fail++; $display("FAIL lock_win[%0d] got %b expected %b", i, obs(), e); end
        end
        q_exp.push_back(ex(1, 0, 0));
        cyc(1, 0, 2'b00);
        e = q_exp.pop_front(); n_chk++;
        if (obs() !== e) begin n_fail++; $display("FAIL lock_hold got %b expected %b", obs(), e); end
    endtask

    task automatic test_locked_invalid();
        for (int i = 0; i < 64; i++) begin
            q_exp.push_back(ex(1, 0, (i == 63) ? 0 : (i < 15) ? i + 1 : 15));
            cyc(1, 1, (i < 15) ? ((i % 2) ? 2'b11 : 2'b00) : 2'b01);
            e = q_exp.pop_front(); n_chk++;
            if (obs() !== e) begin n_fail++; $display("FAIL inv15[%0d] got %b expected %b", i, obs(), e); end
        end
        for (int i = 0; i < 26; i++) begin
            q_exp.push_back(ex(i != 25, i == 25, (i < 10 || i == 25) ? 0 : i - 9));
            cyc(1, 1, (i >= 10) ? 2'b11 : 2'b10);
            e = q_exp.pop_front(); n_chk++;
            if (obs() !== e) begin n_fail++; $display("FAIL inv16[%0d] got %b expected %b", i, obs(), e); end
        end
        q_exp.push_back(ex(0, 0, 0));
        cyc(1, 0, 2'b11);
        e = q_exp.pop_front(); n_chk++;
        if (obs() !== e) begin n_fail++; $display("FAIL inv16_after got %b expected %b", obs(), e); end
    endtask

    task automatic test_slip();
        for (int i = 0; i < 2; i++) begin
            q_exp.push_back(ex(0, 0, 0));
            cyc(1, 1, 2'b11);
            e = q_exp.pop_front(); n_chk++;
            if (obs() !== e) begin n_fail++; $display("FAIL slip_discard_a[%0d] got %b expected %b", i, obs(), e); end
        end
        for (int i = 0; i < 11; i++) begin
            q_exp.push_back(ex(0, i == 10, 0));
            cyc(1, 1, (i == 10) ? 2'b11 : 2'b01);
            e = q_exp.pop_front(); n_chk++;
            if (obs() !== e) begin n_fail++; $display("FAIL slip_test[%0d] got %b expected %b", i, obs(), e); end
        end
        for (int i = 0; i < 2; i++) begin
            q_exp.push_back(ex(0, 0, 0));
            cyc(1, 1, 2'b11);
            e = q_exp.pop_front(); n_chk++;
            if (obs() !== e) begin n_fail++; $display("FAIL slip_discard_b[%0d] got %b expected %b", i, obs(), e); end
        end
        for (int i = 0; i < 64; i++) begin
            q_exp.push_back(ex(i == 63, 0, 0));
            cyc(1, 1, 2'b10);
            e = q_exp.pop_front(); n_chk++;
            if (obs() !== e) begin n_fail++; $display("FAIL slip_relock[%0d] got %b expected %b", i, obs(), e); end
        end
    endtask

    task automatic test_priority();
        for (int i = 0; i < 64; i++) begin
            q_exp.push_back(ex(i != 63, i == 63, (i < 48 || i == 63) ? 0 : i - 47));
            cyc(1, 1, (i >= 48) ? 2'b00 : 2'b01);
            e = q_exp.pop_front(); n_chk++;
            if (obs() !== e) begin n_fail++; $display("FAIL prio[%0d] got %b expected %b", i, obs(), e); end
        end
        for (int i = 0; i < 3; i++) begin
            q_exp.push_back(ex(0, 0, 0));
            cyc(1, i != 1, 2'b00);
            e = q_exp.pop_front(); n_chk++;
            if (obs() !== e) begin n_fail++; $display("FAIL prio_wait[%0d] got %b expected %b", i, obs(), e); end
        end
        for (int i = 0; i < 64; i++) begin
            q_exp.push_back(ex(i == 63, 0, 0));
            cyc(1, 1, 2'b01);
            e = q_exp.pop_front(); n_chk++;
            if (obs() !== e) begin n_fail++; $display("FAIL prio_relock[%0d] got %b expected %b", i, obs(), e); end
        end
    endtask

    task automatic test_signal_drop();
        for (int i = 0; i < 3; i++) begin
            q_exp.push_back(ex(1, 0, i + 1));
            cyc(1, 1, 2'b11);
            e = q_exp.pop_front(); n_chk++;
            if (obs() !== e) begin n_fail++; $display("FAIL drop_pre[%0d] got %b expected %b", i, obs(), e); end
        end
        q_exp.push_back(ex(0, 0, 0));
        cyc(0, 1, 2'b00);
        e = q_exp.pop_front(); n_chk++;
        if (obs() !== e) begin n_fail++; $display("FAIL drop_edge got %b expected %b", obs(), e); end
        q_exp.push_back(ex(0, 0, 0));
        cyc(1, 0, 2'b00);
        e = q_exp.pop_front(); n_chk++;
        if (obs() !== e) begin n_fail++; $display("FAIL drop_init got %b expected %b", obs(), e); end
        for (int i = 0; i < 64; i++) begin
            q_exp.push_back(ex(i == 63, 0, 0));
            cyc(1, 1, 2'b01);
            e = q_exp.pop_front(); n_chk++;
            if (obs() !== e) begin n_fail++; $display("FAIL drop_relock[%0d] got %b expected %b", i, obs(), e); end
        end
    endtask

    task automatic test_gaps();
        int   nv;
        logic v;
        logic [1:0] h;
        nv = 0;
        q_exp.push_back(ex(0, 0, 0));
        cyc(0, 0, 2'b00);
        e = q_exp.pop_front(); n_chk++;
        if (obs() !== e) begin n_fail++; $display("FAIL gaps_drop got %b expected %b", obs(), e); end
        cyc(1, 0, 2'b00);
        for (int c = 0; c < 600 && nv < 64; c++) begin
            v  = 1'($urandom_range(0, 1));
            h  = v ? ($urandom_range(0, 1) ? 2'b01 : 2'b10) : ($urandom_range(0, 1) ? 2'b00 : 2'b11);
            nv += int'(v);
            q_exp.push_back(ex(nv >= 64, 0, 0));
            cyc(1, v, h);
            e = q_exp.pop_front(); n_chk++;
            if (obs() !== e) begin n_fail++; $display("FAIL gaps[%0d] nv=%0d got %b expected %b", c, nv, obs(), e); end
        end
        n_chk++;
        if (nv < 64) begin n_fail++; $display("FAIL gaps_budget got %0d valid blocks expected 64", nv); end
    endtask

    task automatic test_reset_midwindow();
        nreset = 1'b0;
        #1;
        n_chk++;
        if (obs() !== ex(0, 0, 0)) begin n_fail++; $display("FAIL async_rst_lock got %b expected %b", obs(), ex(0, 0, 0)); end
        cyc(1, 1, 2'b01);
        nreset = 1'b1;
        cyc(1, 0, 2'b00);
        for (int i = 0; i < 30; i++) cyc(1, 1, 2'b01);
        nreset = 1'b0;
        #1;
        nreset = 1'b1;
        cyc(1, 0, 2'b00);
        for (int i = 0; i < 64; i++) begin
            q_exp.push_back(ex(i == 63, 0, 0));
            cyc(1, 1, 2'b10);
            e = q_exp.pop_front(); n_chk++;
            if (obs() !== e) begin n_fail++; $display("FAIL rst_win[%0d] got %b expected %b", i, obs(), e); end
        end
    endtask

    task automatic test_reset_slipwait();
        cyc(0, 0, 2'b00);
        cyc(1, 0, 2'b00);
        q_exp.push_back(ex(0, 1, 0));
        cyc(1, 1, 2'b11);
        e = q_exp.pop_front(); n_chk++;
        if (obs() !== e) begin n_fail++; $display("FAIL sw_slip got %b expected %b", obs(), e); end
        nreset = 1'b0;
        #1;
        n_chk++;
        if (obs() !== ex(0, 0, 0)) begin n_fail++; $display("FAIL sw_async got %b expected %b", obs(), ex(0, 0, 0)); end
        cyc(1, 1, 2'b01);
        nreset = 1'b1;
        q_exp.push_back(ex(0, 0, 0));
        cyc(1, 0, 2'b00);
        e = q_exp.pop_front(); n_chk++;
        if (obs() !== e) begin n_fail++; $display("FAIL sw_release got %b expected %b", obs(), e); end
        for (int i = 0; i < 64; i++) begin
            q_exp.push_back(ex(i == 63, 0, 0));
            cyc(1, 1, 2'b01);
            e = q_exp.pop_front(); n_chk++;
            if (obs() !== e) begin n_fail++; $display("FAIL sw_relock[%0d] got %b expected %b", i, obs(), e); end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_locked_invalid();
        test_slip();
        test_priority();
        test_signal_drop();
        test_gaps();
        test_reset_midwindow();
        test_reset_slipwait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
